// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared defaults and types
// for the wide-write fetch queue.
package fetch_queue_pkg;

  localparam int FQ_WORD_W       = 32;
  localparam int FQ_WORDS_PER_WR = 4;
  localparam int FQ_DEPTH        = 16;

  typedef logic [FQ_WORD_W-1:0] word_t;

endpackage

// File: rtl/fq_wide_wr_mem.sv
// fq_wide_wr_mem: word array with one wide
// aligned write port and one async word read.
module fq_wide_wr_mem
  import fetch_queue_pkg::*;
#(
  parameter int WORD_W       = FQ_WORD_W,
  parameter int WORDS_PER_WR = FQ_WORDS_PER_WR,
  parameter int DEPTH        = FQ_DEPTH
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH)-1:0]       wr_addr,
  input  logic [WORD_W*WORDS_PER_WR-1:0] wr_data,
  input  logic [$clog2(DEPTH)-1:0]       rd_addr,
  output logic [WORD_W-1:0]              rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];

  // Store a whole beat; word i lands at wr_addr+i.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WORDS_PER_WR; i++) begin
        mem[wr_addr + AW'(i)] <= wr_data[i*WORD_W +: WORD_W];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wide_wr_fetch_fifo.sv
// wide_wr_fetch_fifo: multi-word write beats in,
// one registered word out per pop.
module wide_wr_fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int WORD_W       = FQ_WORD_W,
  parameter int WORDS_PER_WR = FQ_WORDS_PER_WR,
  parameter int DEPTH        = FQ_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [WORD_W*WORDS_PER_WR-1:0] wr_data,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [WORD_W-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0]   WPW_C   = WORDS_PER_WR[AW:0];
  localparam logic [AW-1:0] WPW_P   = WORDS_PER_WR[AW-1:0];

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       arr_cnt;
  logic [AW:0]       arr_cnt_nxt;
  logic              rd_valid_nxt;
  logic              wr_en;
  logic              pop;
  logic              refill;
  logic [WORD_W-1:0] mem_rdata;

  // Space check uses only registered occupancy.
  assign wr_ready = !rst && !flush
                  && ((DEPTH_C - arr_cnt) >= WPW_C);

  fq_wide_wr_mem #(
    .WORD_W       (WORD_W),
    .WORDS_PER_WR (WORDS_PER_WR),
    .DEPTH        (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rdata)
  );

  // Handshake decode and next occupancy / head state.
  always_comb begin
    wr_en        = wr_valid && wr_ready;
    pop          = rd_valid && rd_ready;
    refill       = (!rd_valid || pop) && (arr_cnt != '0);
    arr_cnt_nxt  = arr_cnt;
    rd_valid_nxt = rd_valid;
    if (wr_en) arr_cnt_nxt = arr_cnt_nxt + WPW_C;
    if (refill) begin
      arr_cnt_nxt  = arr_cnt_nxt - 1'b1;
      rd_valid_nxt = 1'b1;
    end else if (pop) begin
      rd_valid_nxt = 1'b0;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      arr_cnt  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      count    <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      arr_cnt  <= '0;
      rd_valid <= 1'b0;
      count    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + WPW_P;
      if (refill) begin
        rd_data <= mem_rdata;
        rd_ptr  <= rd_ptr + 1'b1;
      end
      arr_cnt  <= arr_cnt_nxt;
      rd_valid <= rd_valid_nxt;
      count    <= arr_cnt_nxt + {{AW{1'b0}}, rd_valid_nxt};
    end
  end

endmodule

// File: tb/tb_wide_wr_fetch_fifo.sv
// tb_wide_wr_fetch_fifo: randomized bench with a
// queue-based reference model of the fetch queue.
module tb_wide_wr_fetch_fifo;

  localparam int W   = 32;
  localparam int WPW = 4;
  localparam int D   = 16;
  localparam int BW  = W * WPW;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [BW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic [4:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: words in the array, plus head
  logic [W-1:0] m_arr[$];
  bit           m_ov;
  logic [W-1:0] m_ow;
  bit           m_acc;

  always #5 clk = ~clk;

  wide_wr_fetch_fifo #(
    .WORD_W       (W),
    .WORDS_PER_WR (WPW),
    .DEPTH        (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count)
  );

  function automatic logic [BW-1:0] mk_beat(logic [W-1:0] base);
    logic [BW-1:0] b;
    for (int i = 0; i < WPW; i++) b[i*W +: W] = base + W'(i);
    return b;
  endfunction

  function automatic logic [BW-1:0] rnd_beat();
    logic [BW-1:0] b;
    for (int i = 0; i < WPW; i++) b[i*W +: W] = $urandom;
    return b;
  endfunction

  function automatic bit exp_wr_ready();
    return !rst && !flush && (D - m_arr.size() >= WPW);
  endfunction

  function automatic int exp_count();
    return m_arr.size() + int'(m_ov);
  endfunction

  task automatic model_reset();
    m_arr.delete();
    m_ov = 1'b0;
    m_ow = '0;
  endtask

  task automatic model_edge(bit fl, bit wv,
                            logic [BW-1:0] wd, bit rr);
    bit pop;
    m_acc = 1'b0;
    if (fl) begin
      m_arr.delete();
      m_ov = 1'b0;
      return;
    end
    pop   = m_ov && rr;
    m_acc = wv && (D - m_arr.size() >= WPW);
    if ((!m_ov || pop) && m_arr.size() > 0) begin
      m_ow = m_arr.pop_front();
      m_ov = 1'b1;
    end else if (pop) begin
      m_ov = 1'b0;
    end
    if (m_acc)
      for (int i = 0; i < WPW; i++) m_arr.push_back(wd[i*W +: W]);
  endtask

  task automatic tick(bit fl, bit wv, logic [BW-1:0] wd, bit rr);
    flush    = fl;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(posedge clk);
    model_edge(fl, wv, wd, rr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0;
    rd_ready = 1'b0; wr_data = '0;
    model_reset();
    #2;
    n_checks++;
    if (rd_valid !== 1'b0 || wr_ready !== 1'b0 ||
        count !== 5'd0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b c=%0d d=%h want 0 0 0 0",
               rd_valid, wr_ready, count, rd_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", wr_ready);
    end
  endtask

  task automatic test_basic(string tag);
    tick(1'b0, 1'b1, mk_beat(32'h0), 1'b1);
    n_checks++;
    if (rd_valid !== 1'b0 || count !== 5'd4) begin
      n_fail++;
      $display("FAIL %s_first_edge: got v=%b c=%0d want v=0 c=4",
               tag, rd_valid, count);
    end
    tick(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < WPW; i++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== W'(i) ||
          int'(count) != 4 - i) begin
        n_fail++;
        $display("FAIL %s_word%0d: got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                 tag, i, rd_valid, rd_data, count, W'(i), 4 - i);
      end
      tick(1'b0, 1'b0, '0, 1'b1);
    end
    n_checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL %s_empty: got v=%b c=%0d want v=0 c=0",
               tag, rd_valid, count);
    end
  endtask

  task automatic test_drain(string tag);
    int n = 0;
    while ((m_ov || m_arr.size() > 0) && n < 60) begin
      n_checks++;
      if (rd_valid !== m_ov || (m_ov && rd_data !== m_ow) ||
          int'(count) != exp_count()) begin
        n_fail++;
        $display("FAIL %s_word: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                 tag, rd_valid, rd_data, count, m_ov, m_ow, exp_count());
      end
      tick(1'b0, 1'b0, '0, 1'b1);
      n++;
    end
    n_checks++;
    if (n >= 60 || rd_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL %s_end: got v=%b c=%0d cycles=%0d want v=0 c=0",
               tag, rd_valid, count, n);
    end
  endtask

  task automatic test_fill();
    int base = 32'h1000;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, mk_beat(W'(base)), 1'b0);
      base += 32'h10;
      n_checks++;
      if (int'(count) != exp_count() || wr_ready !== exp_wr_ready()) begin
        n_fail++;
        $display("FAIL fill_beat%0d: got c=%0d r=%b want c=%0d r=%b",
                 i, count, wr_ready, exp_count(), exp_wr_ready());
      end
    end
    n_checks++;
    if (count !== 5'd16 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full16: got c=%0d r=%b want c=16 r=0",
               count, wr_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, mk_beat(W'(base)), 1'b1);
      base += 32'h10;
      n_checks++;
      if (int'(count) != exp_count() || wr_ready !== exp_wr_ready() ||
          rd_data !== m_ow) begin
        n_fail++;
        $display("FAIL fill_pop%0d: got c=%0d r=%b d=%h want c=%0d r=%b d=%h",
                 i, count, wr_ready, rd_data,
                 exp_count(), exp_wr_ready(), m_ow);
      end
    end
    tick(1'b0, 1'b1, mk_beat(W'(base)), 1'b0);
    base += 32'h10;
    tick(1'b0, 1'b1, mk_beat(W'(base)), 1'b0);
    n_checks++;
    if (count !== 5'd17 || wr_ready !== 1'b0 ||
        int'(count) != exp_count()) begin
      n_fail++;
      $display("FAIL fill_full17: got c=%0d r=%b want c=17 r=0",
               count, wr_ready);
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [W-1:0]  sent_q[$];
    logic [BW-1:0] b;
    bit            wv, rr;
    int            beats = 0;
    int            got   = 0;
    int            cyc   = 0;
    while ((beats < 100 || sent_q.size() > 0) && cyc < 3000) begin
      n_checks++;
      if (rd_valid !== m_ov || (m_ov && rd_data !== m_ow) ||
          int'(count) != exp_count() || wr_ready !== exp_wr_ready()) begin
        n_fail++;
        $display("FAIL stream_cycle%0d: got v=%b d=%h c=%0d r=%b want v=%b d=%h c=%0d r=%b",
                 cyc, rd_valid, rd_data, count, wr_ready,
                 m_ov, m_ow, exp_count(), exp_wr_ready());
      end
      wv = (beats < 100) && ($urandom_range(3) != 0);
      rr = $urandom_range(1) != 0;
      b  = rnd_beat();
      if (rd_valid && rr) begin
        n_checks++;
        if (sent_q.size() == 0 || rd_data !== sent_q[0]) begin
          n_fail++;
          $display("FAIL stream_order%0d: got %h want %h",
                   got, rd_data,
                   sent_q.size() ? sent_q[0] : 'x);
        end
        if (sent_q.size() > 0) void'(sent_q.pop_front());
        got++;
      end
      tick(1'b0, wv, b, rr);
      if (m_acc) begin
        beats++;
        for (int i = 0; i < WPW; i++) sent_q.push_back(b[i*W +: W]);
      end
      cyc++;
    end
    n_checks++;
    if (cyc >= 3000 || got != 100 * WPW) begin
      n_fail++;
      $display("FAIL stream_total: got words=%0d cycles=%0d want words=%0d",
               got, cyc, 100 * WPW);
    end
    test_drain("stream_drain");
  endtask

  task automatic test_flush();
    logic [W-1:0] exp_w;
    int           n;
    for (int i = 0; i < 3; i++)
      tick(1'b0, 1'b1, mk_beat(W'(32'h100 + i * 16)), 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (count !== 5'd9 || int'(count) != exp_count()) begin
      n_fail++;
      $display("FAIL flush_pre_count: got %0d want 9", count);
    end
    flush    = 1'b1;
    wr_valid = 1'b1;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_wr_ready: got %b want 0", wr_ready);
    end
    tick(1'b1, 1'b1, mk_beat(32'h900), 1'b0);
    n_checks++;
    if (count !== 5'd0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cleared: got c=%0d v=%b want c=0 v=0",
               count, rd_valid);
    end
    tick(1'b0, 1'b1, mk_beat(32'h200), 1'b1);
    wr_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (rd_valid) begin
        exp_w = 32'h200 + W'(n);
        n_checks++;
        if (rd_data !== exp_w) begin
          n_fail++;
          $display("FAIL flush_new_word%0d: got %h want %h",
                   n, rd_data, exp_w);
        end
        n++;
      end
      tick(1'b0, 1'b0, '0, 1'b1);
    end
    n_checks++;
    if (n != WPW || count !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_new_total: got words=%0d c=%0d want %0d c=0",
               n, count, WPW);
    end
  endtask

  task automatic test_hold();
    tick(1'b0, 1'b1, mk_beat(32'h5000), 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, rnd_beat(), 1'b0);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h5000 ||
          int'(count) != exp_count()) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got v=%b d=%h c=%0d want v=1 d=5000 c=%0d",
                 i, rd_valid, rd_data, count, exp_count());
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b1, mk_beat(32'h7000), 1'b0);
    tick(1'b0, 1'b1, mk_beat(32'h7100), 1'b1);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rd_valid !== 1'b0 || wr_ready !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b r=%b c=%0d want 0 0 0",
               rd_valid, wr_ready, count);
    end
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    model_reset();
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_release_ready: got %b want 1", wr_ready);
    end
    test_basic("post_rst");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_fill();
    test_drain("fill_drain");
    test_stream();
    test_flush();
    test_hold();
    test_drain("hold_drain");
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
